// File: rtl/dht11_ascii_reporter.sv
// Converts one DHT11 reading to ASCII ("H=hhh.hhh T=ttt.ttt" with optional CRLF)
// and streams it one character at a time over a valid/ready handshake.
module dht11_ascii_reporter #(
    parameter bit ENABLE_CRLF = 1'b1
) (
    input  logic        clk50M,
    input  logic        rst,
    input  logic [31:0] dht11_data,
    input  logic        dht11_data_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned MSG_LEN = ENABLE_CRLF ? 21 : 19;

    typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [31:0]         r_snap;
    logic [5:0]          r_cnt;
    logic [11:0]         r_work;
    logic [3:0][11:0]    r_bcd;
    logic [4:0]          r_idx;
    logic [7:0]          r_tx_data;
    logic [7:0]          r_drop;
    logic                w_accept;
    logic                w_last;
    logic                w_bit;
    logic [11:0]         w_dabble;

    // One double-dabble iteration: add 3 to any digit >= 5, then shift in the next bit.
    function automatic logic [11:0] dabble_step(input logic [11:0] v, input logic b);
        logic [11:0] a;
        a = v;
        for (int i = 0; i < 3; i++) begin
            if (a[i*4 +: 4] >= 4'd5)
                a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
        end
        return {a[10:0], b};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // bcd[0..3] = humidity int, humidity dec, temperature int, temperature dec.
    function automatic logic [7:0] msg_char(input logic [4:0] idx, input logic [3:0][11:0] bcd);
        case (idx)
            5'd0:    return 8'h48;
            5'd1:    return 8'h3D;
            5'd2:    return ascii_digit(bcd[0][11:8]);
            5'd3:    return ascii_digit(bcd[0][7:4]);
            5'd4:    return ascii_digit(bcd[0][3:0]);
            5'd5:    return 8'h2E;
            5'd6:    return ascii_digit(bcd[1][11:8]);
            5'd7:    return ascii_digit(bcd[1][7:4]);
            5'd8:    return ascii_digit(bcd[1][3:0]);
            5'd9:    return 8'h20;
            5'd10:   return 8'h54;
            5'd11:   return 8'h3D;
            5'd12:   return ascii_digit(bcd[2][11:8]);
            5'd13:   return ascii_digit(bcd[2][7:4]);
            5'd14:   return ascii_digit(bcd[2][3:0]);
            5'd15:   return 8'h2E;
            5'd16:   return ascii_digit(bcd[3][11:8]);
            5'd17:   return ascii_digit(bcd[3][7:4]);
            5'd18:   return ascii_digit(bcd[3][3:0]);
            5'd19:   return 8'h0D;
            5'd20:   return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    // Snapshot is consumed MSB first, so byte 0 of the conversion is humidity integer.
    assign w_bit    = r_snap[5'd31 - r_cnt[4:0]];
    assign w_dabble = dabble_step(r_work, w_bit);

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_idx == 5'(MSG_LEN - 1));
        case (r_state)
            IDLE: if (dht11_data_valid) w_state_next = CONV;
            CONV: if (r_cnt[5])         w_state_next = SEND;
            SEND: begin
                w_accept = tx_ready;
                if (tx_ready && w_last) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk50M) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            r_snap    <= '0;
            r_cnt     <= '0;
            r_work    <= '0;
            r_bcd     <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
            r_drop    <= '0;
        end else begin
            if (dht11_data_valid) begin
                if (r_state == IDLE) begin
                    r_snap <= dht11_data;
                    r_cnt  <= '0;
                    r_work <= '0;
                end else begin
                    r_drop <= sat_inc(r_drop);
                end
            end
            case (r_state)
                CONV: begin
                    if (!r_cnt[5]) begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_cnt[2:0] == 3'd7) begin
                            r_bcd[r_cnt[4:3]] <= w_dabble;
                            r_work            <= '0;
                        end else begin
                            r_work <= w_dabble;
                        end
                    end else begin
                        r_idx     <= '0;
                        r_tx_data <= msg_char(5'd0, r_bcd);
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_tx_data <= '0;
                        end else begin
                            r_idx     <= r_idx + 5'd1;
                            r_tx_data <= msg_char(r_idx + 5'd1, r_bcd);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = (r_state == SEND);
    assign busy     = (r_state != IDLE);
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_dht11_ascii_reporter.sv
// Scoreboard bench for dht11_ascii_reporter: CRLF instance (dut0) and no-CRLF instance (dut1)
// share stimulus; accepted characters are logged and compared against a decimal-arithmetic model.
module tb_dht11_ascii_reporter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dht11_data = '0;
    logic        dht11_data_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data0, tx_data1, drop_cnt0, drop_cnt1;
    logic        tx_valid0, tx_valid1, busy0, busy1;

    logic [7:0]  q_exp0[$];
    logic [7:0]  q_exp1[$];
    logic [7:0]  q_got0[$];
    logic [7:0]  q_got1[$];
    int          checks = 0;
    int          failures = 0;

    always #10 clk = ~clk;

    dht11_ascii_reporter #(.ENABLE_CRLF(1'b1)) dut0 (
        .clk50M(clk), .rst(rst), .dht11_data(dht11_data), .dht11_data_valid(dht11_data_valid),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready), .busy(busy0), .drop_cnt(drop_cnt0));

    dht11_ascii_reporter #(.ENABLE_CRLF(1'b0)) dut1 (
        .clk50M(clk), .rst(rst), .dht11_data(dht11_data), .dht11_data_valid(dht11_data_valid),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready), .busy(busy1), .drop_cnt(drop_cnt1));

    // Log every character that the next rising edge will accept.
    always @(negedge clk) begin
        if (!rst && tx_valid0 && tx_ready) q_got0.push_back(tx_data0);
        if (!rst && tx_valid1 && tx_ready) q_got1.push_back(tx_data1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_msg(input logic [31:0] d, input bit to_dut1);
        logic [7:0] m[$];
        logic [7:0] f;
        m.push_back(8'h48);
        m.push_back(8'h3D);
        for (int k = 3; k >= 0; k--) begin
            f = d[k*8 +: 8];
            if (k == 2 || k == 0) m.push_back(8'h2E);
            if (k == 1) begin
                m.push_back(8'h20); m.push_back(8'h54); m.push_back(8'h3D);
            end
            m.push_back(8'h30 + f / 8'd100);
            m.push_back(8'h30 + (f / 8'd10) % 8'd10);
            m.push_back(8'h30 + f % 8'd10);
        end
        if (to_dut1) begin
            foreach (m[i]) q_exp1.push_back(m[i]);
        end else begin
            m.push_back(8'h0D);
            m.push_back(8'h0A);
            foreach (m[i]) q_exp0.push_back(m[i]);
        end
    endtask

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic pulse(input logic [31:0] d);
        dht11_data       = d;
        dht11_data_valid = 1'b1;
        @(posedge clk); #1;
        dht11_data_valid = 1'b0;
    endtask

    task automatic wait_idle0(input int max, output int n);
        n = 0;
        while (busy0 && n < max) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait_got0(input int cnt, input int max, output bit timed_out);
        int n;
        n = 0;
        while (q_got0.size() < cnt && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        timed_out = (q_got0.size() < cnt);
    endtask

    task automatic test_reset();
        logic [7:0] g;
        rst = 1'b1;
        dht11_data = 32'h35001825;
        dht11_data_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_valid0 !== 1'b0 || tx_data0 !== 8'h00 || busy0 !== 1'b0 || drop_cnt0 !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: valid=%b data=%h busy=%b drop=%0d required 0/00/0/0",
                     tx_valid0, tx_data0, busy0, drop_cnt0);
        end
        rst = 1'b0;
        dht11_data_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulse_ignored: busy=%b required 0", busy0);
        end
        q_got0.delete(); q_got1.delete();
        g = 8'h00;
    endtask

    task automatic test_nominal();
        bit early;
        int n;
        logic [7:0] e, g;
        tx_ready = 1'b1;
        q_got0.delete();
        push_msg(32'h35001825, 1'b0);
        pulse(32'h35001825);
        checks++;
        if (busy0 !== 1'b1) begin
            failures++;
            $display("FAIL nominal_busy: busy=%b required 1", busy0);
        end
        early = 1'b0;
        repeat (32) begin
            @(posedge clk); #1;
            early |= tx_valid0;
        end
        checks++;
        if (early !== 1'b0) begin
            failures++;
            $display("FAIL nominal_conv_valid: tx_valid seen during conversion, required 0");
        end
        @(posedge clk); #1;
        checks++;
        if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h48) begin
            failures++;
            $display("FAIL nominal_first_char: valid=%b data=%h required 1/48", tx_valid0, tx_data0);
        end
        wait_idle0(100, n);
        checks++;
        if (n !== 21) begin
            failures++;
            $display("FAIL nominal_cycles: busy for %0d edges after first char, required 21", n);
        end
        checks++;
        if (q_got0.size() !== q_exp0.size()) begin
            failures++;
            $display("FAIL nominal_len: got %0d bytes required %0d", q_got0.size(), q_exp0.size());
        end
        while (q_exp0.size() > 0 && q_got0.size() > 0) begin
            e = q_exp0.pop_front(); g = q_got0.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL nominal_byte: got %h required %h", g, e);
            end
        end
        q_exp0.delete(); q_got0.delete();
    endtask

    task automatic test_extremes();
        logic [31:0] vals[2];
        int n;
        logic [7:0] e, g;
        vals[0] = 32'hFFFFFFFF;
        vals[1] = 32'h00000000;
        tx_ready = 1'b1;
        foreach (vals[v]) begin
            q_got0.delete();
            push_msg(vals[v], 1'b0);
            pulse(vals[v]);
            wait_idle0(200, n);
            checks++;
            if (busy0 !== 1'b0 || q_got0.size() !== q_exp0.size()) begin
                failures++;
                $display("FAIL extreme_len: data=%h busy=%b got %0d bytes required %0d",
                         vals[v], busy0, q_got0.size(), q_exp0.size());
            end
            while (q_exp0.size() > 0 && q_got0.size() > 0) begin
                e = q_exp0.pop_front(); g = q_got0.pop_front();
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL extreme_byte: data=%h got %h required %h", vals[v], g, e);
                end
            end
            q_exp0.delete(); q_got0.delete();
        end
    endtask

    task automatic test_backpressure();
        bit to;
        bit bad;
        int n;
        logic [7:0] e, g;
        tx_ready = 1'b1;
        q_got0.delete();
        push_msg(32'h35001825, 1'b0);
        pulse(32'h35001825);
        wait_got0(5, 100, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL bp_wait: got %0d bytes required 5", q_got0.size());
        end
        tx_ready = 1'b0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid0 !== 1'b1 || tx_data0 !== 8'h2E) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_hold: valid=%b data=%h required 1/2e throughout", tx_valid0, tx_data0);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_idle0(100, n);
        checks++;
        if (busy0 !== 1'b0 || q_got0.size() !== q_exp0.size()) begin
            failures++;
            $display("FAIL bp_len: busy=%b got %0d bytes required %0d", busy0, q_got0.size(), q_exp0.size());
        end
        while (q_exp0.size() > 0 && q_got0.size() > 0) begin
            e = q_exp0.pop_front(); g = q_got0.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL bp_byte: got %h required %h", g, e);
            end
        end
        q_exp0.delete(); q_got0.delete();
    endtask

    task automatic test_overlap();
        bit to;
        logic [7:0] e, g;
        tx_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_got0.delete();
        push_msg(32'h35001825, 1'b0);
        pulse(32'h35001825);
        wait_got0(8, 100, to);
        pulse(32'h11223344);
        wait_got0(20, 100, to);
        checks++;
        if (to || tx_valid0 !== 1'b1 || tx_data0 !== 8'h0A) begin
            failures++;
            $display("FAIL overlap_last_char: got %0d bytes valid=%b data=%h required 20/1/0a",
                     q_got0.size(), tx_valid0, tx_data0);
        end
        pulse(32'h55667788);
        checks++;
        if (busy0 !== 1'b0 || tx_valid0 !== 1'b0 || drop_cnt0 !== 8'd2) begin
            failures++;
            $display("FAIL overlap_end: busy=%b valid=%b drop=%0d required 0/0/2", busy0, tx_valid0, drop_cnt0);
        end
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || q_got0.size() !== q_exp0.size()) begin
            failures++;
            $display("FAIL overlap_len: busy=%b got %0d bytes required %0d", busy0, q_got0.size(), q_exp0.size());
        end
        while (q_exp0.size() > 0 && q_got0.size() > 0) begin
            e = q_exp0.pop_front(); g = q_got0.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL overlap_byte: got %h required %h", g, e);
            end
        end
        q_exp0.delete(); q_got0.delete();
        // Hold the reporter in SEND so every pulse lands while busy.
        tx_ready = 1'b0;
        pulse(32'h12345678);
        dht11_data_valid = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        dht11_data_valid = 1'b0;
        checks++;
        if (drop_cnt0 !== 8'd255) begin
            failures++;
            $display("FAIL overlap_saturate: drop=%0d required 255", drop_cnt0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (drop_cnt0 !== 8'd0 || busy0 !== 1'b0) begin
            failures++;
            $display("FAIL overlap_reset: drop=%0d busy=%b required 0/0", drop_cnt0, busy0);
        end
        tx_ready = 1'b1;
        q_got0.delete(); q_got1.delete();
    endtask

    task automatic test_reset_mid_send();
        bit to;
        int n;
        logic [7:0] e, g;
        tx_ready = 1'b1;
        q_got0.delete();
        push_msg(32'h35001825, 1'b0);
        pulse(32'h35001825);
        wait_got0(3, 100, to);
        pulse(32'hAABBCCDD);
        wait_got0(7, 100, to);
        rst = 1'b1;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (tx_valid0 !== 1'b0 || drop_cnt0 !== 8'd0 || busy0 !== 1'b0 || tx_data0 !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid_send: valid=%b drop=%0d busy=%b data=%h required 0/0/0/00",
                     tx_valid0, drop_cnt0, busy0, tx_data0);
        end
        checks++;
        if (q_got0.size() !== 7) begin
            failures++;
            $display("FAIL rst_prefix_len: got %0d bytes required 7", q_got0.size());
        end
        while (q_got0.size() > 0 && q_exp0.size() > 0) begin
            e = q_exp0.pop_front(); g = q_got0.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL rst_prefix_byte: got %h required %h", g, e);
            end
        end
        q_exp0.delete(); q_got0.delete();
        tx_ready = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        if (q_got0.size() !== 0) begin
            failures++;
            $display("FAIL rst_no_more_chars: got %0d bytes required 0", q_got0.size());
        end
        q_got0.delete();
        push_msg(32'h35001825, 1'b0);
        pulse(32'h35001825);
        wait_idle0(200, n);
        checks++;
        if (busy0 !== 1'b0 || q_got0.size() !== q_exp0.size()) begin
            failures++;
            $display("FAIL rst_restart_len: busy=%b got %0d bytes required %0d", busy0, q_got0.size(), q_exp0.size());
        end
        while (q_exp0.size() > 0 && q_got0.size() > 0) begin
            e = q_exp0.pop_front(); g = q_got0.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL rst_restart_byte: got %h required %h", g, e);
            end
        end
        q_exp0.delete(); q_got0.delete();
    endtask

    task automatic test_no_crlf();
        int n;
        logic [7:0] e, g;
        tx_ready = 1'b1;
        q_got1.delete();
        q_exp1.delete();
        push_msg(32'h35001825, 1'b1);
        pulse(32'h35001825);
        n = 0;
        while (busy1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy1 !== 1'b0 || tx_valid1 !== 1'b0 || q_got1.size() !== 19) begin
            failures++;
            $display("FAIL nocrlf_len: busy=%b valid=%b got %0d bytes required 0/0/19",
                     busy1, tx_valid1, q_got1.size());
        end
        while (q_exp1.size() > 0 && q_got1.size() > 0) begin
            e = q_exp1.pop_front(); g = q_got1.pop_front();
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL nocrlf_byte: got %h required %h", g, e);
            end
        end
        q_exp1.delete(); q_got1.delete();
        wait_idle0(200, n);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_extremes();
        test_backpressure();
        test_overlap();
        test_reset_mid_send();
        test_no_crlf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dht11_ascii_reporter.md
DHT11_ASCII_REPORTER -- requirements
Module: dht11_ascii_reporter

Interface
REQ-001 SHALL have parameter: ENABLE_CRLF, 1, when 1 append CR (0x0D) and LF (0x0A) to each message; when 0 omit both.
REQ-002 SHALL have port: clk50M  input  1  single 50 MHz clock; all logic on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: dht11_data  input  32  decoded reading: [31:24] humidity integer, [23:16] humidity decimal, [15:8] temperature integer, [7:0] temperature decimal.
REQ-005 SHALL have port: dht11_data_valid  input  1  one-cycle pulse; dht11_data is valid in that cycle only.
REQ-006 SHALL have port: tx_data  output  8  ASCII character to the UART transmitter.
REQ-007 SHALL have port: tx_valid  output  1  tx_data holds a character.
REQ-008 SHALL have port: tx_ready  input  1  UART accepts tx_data on an edge where tx_valid and tx_ready are both 1.
REQ-009 SHALL have port: busy  output  1  a reading is being converted or sent.
REQ-010 SHALL have port: drop_cnt  output  8  count of readings dropped while busy, saturating.

Function
REQ-011 SHALL have FSM states IDLE, CONV and SEND.
REQ-012 In IDLE, on edge N with dht11_data_valid=1, SHALL capture dht11_data into a snapshot register, enter CONV and set busy=1 after edge N.
REQ-013 CONV SHALL convert each snapshot byte to three BCD digits (000-255) by sequential double-dabble, one shift per edge, 32 edges total (edges N+1..N+32).
REQ-014 At edge N+33, SHALL enter SEND with tx_valid=1 and tx_data equal to the first character.
REQ-015 Message SHALL be "H=" d2 d1 d0 "." d2 d1 d0 " T=" d2 d1 d0 "." d2 d1 d0, then "\r\n" when ENABLE_CRLF=1: 21 bytes, or 19 bytes when ENABLE_CRLF=0.
REQ-016 The digit fields SHALL appear in the order humidity integer, humidity decimal, temperature integer, temperature decimal; each digit SHALL be sent as 0x30+digit with leading zeros kept.
REQ-017 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable.
REQ-018 On each accept edge, SHALL advance to the next character; the next character SHALL appear with tx_valid=1 in the following cycle.
REQ-019 tx_valid SHALL remain 1 across back-to-back accepts, giving one character per cycle when tx_ready stays high.
REQ-020 On the accept of the last character, SHALL return to IDLE; tx_valid=0 and busy=0 after that edge.
REQ-021 A dht11_data_valid pulse while busy=1, including the edge that accepts the last character, SHALL be dropped, leave the snapshot unchanged, and increment drop_cnt.
REQ-022 drop_cnt SHALL saturate at 255.
REQ-023 tx_valid SHALL be 0 in IDLE and CONV.
REQ-024 tx_ready SHALL be ignored outside SEND.
REQ-025 Conversion SHALL be exact for all 256 values of each byte; no clamping.

Reset
REQ-026 While rst=1, SHALL force state=IDLE, tx_valid=0, tx_data=0x00, busy=0, drop_cnt=0, and clear the snapshot, BCD registers and character index.
REQ-027 rst has priority over all other inputs; a dht11_data_valid pulse in the same cycle as rst=1 SHALL be ignored.
REQ-028 rst asserted mid-CONV or mid-SEND SHALL abort the message with no further characters; the next message after reset SHALL start at "H".

Verification
REQ-029 Nominal: tx_ready=1, dht11_data=0x35001825 pulsed at edge N -> first tx_valid after edge N+33; bytes "H=053.000 T=024.037\r\n" (21 bytes) on consecutive cycles; busy low after the last accept.
REQ-030 Extremes: 0xFFFFFFFF -> "H=255.255 T=255.255\r\n"; 0x00000000 -> "H=000.000 T=000.000\r\n".
REQ-031 Backpressure: tx_ready=0 for 10 cycles while character index 5 ('.') is presented -> tx_data=0x2E held for all 10 cycles; full message intact, with no duplicated or lost bytes.
REQ-032 Overlap: second pulse (0x11223344) mid-SEND, and a third pulse on the final accept edge -> first message unchanged, drop_cnt=2, no second message; 260 overlapping pulses -> drop_cnt=255.
REQ-033 Reset mid-SEND after 7 characters -> tx_valid=0 and drop_cnt=0 next cycle; a new pulse with 0x35001825 -> complete correct message from "H".
REQ-034 ENABLE_CRLF=0 with 0x35001825 -> exactly 19 bytes ending "037", then IDLE.
